mem_wb_stage: RTL and testbench

- Pipeline stage directly downstream of the data-memory stage in the RV32IF core.
- Captures the memory stage's 32-bit read word together with the ALU result and link address.
- Performs load extraction and sign/zero extension, then selects the writeback value.
- Presents the result to integer/FP register-file writeback through a 2-entry valid/ready skid buffer; also provides a forwarding tap and a retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_wb_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory/writeback pipeline stage: load formatting, writeback select, 2-entry skid buffer, forwarding tap.
// Optional misaligned-load trap output enabled by defining MEM_WB_MISALIGN_TRAP_EN.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RA_W-1:0]   in_rd,
  input  logic              in_reg_write,
  input  logic              in_rd_is_fp,
  input  logic [1:0]        in_wb_sel,
  input  logic [2:0]        in_funct3,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RA_W-1:0]   wb_rd,
  output logic              wb_we_int,
  output logic              wb_we_fp,
  output logic [DATA_W-1:0] wb_data,
`ifdef MEM_WB_MISALIGN_TRAP_EN
  output logic              misalign_trap,
`endif
  output logic              fwd_valid,
  output logic [RA_W-1:0]   fwd_rd,
  output logic              fwd_is_fp,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_count
);

  typedef struct packed {
    logic [RA_W-1:0]   rd;
    logic              is_fp;
    logic              we_int;
    logic              we_fp;
`ifdef MEM_WB_MISALIGN_TRAP_EN
    logic              trap;
`endif
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic [DATA_W-1:0] load_extract(input logic [2:0] f3,
                                                     input logic [DATA_W-1:0] w);
    case (f3)
      3'b000:  return {{(DATA_W-8){w[7]}}, w[7:0]};
      3'b001:  return {{(DATA_W-16){w[15]}}, w[15:0]};
      3'b010:  return w;
      3'b100:  return {{(DATA_W-8){1'b0}}, w[7:0]};
      3'b101:  return {{(DATA_W-16){1'b0}}, w[15:0]};
      default: return '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] wb_select(input logic [1:0] sel,
                                                  input logic [DATA_W-1:0] alu,
                                                  input logic [DATA_W-1:0] ld,
                                                  input logic [DATA_W-1:0] link);
    case (sel)
      2'b00:   return alu;
      2'b01:   return ld;
      2'b10:   return link;
      default: return '0;
    endcase
  endfunction

  entry_t             in_e, h_q, h_d, s_q, s_d;
  logic               h_vld_q, h_vld_d, s_vld_q, s_vld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept, drain, mis;

  // Incoming instruction is fully formatted before capture
  always_comb begin
    mis = 1'b0;
`ifdef MEM_WB_MISALIGN_TRAP_EN
    if (in_wb_sel == 2'b01) begin
      case (in_funct3)
        3'b001, 3'b101: mis = in_alu_result[0];
        3'b010:         mis = (in_alu_result[1:0] != 2'b00);
        default:        mis = 1'b0;
      endcase
    end
    in_e.trap   = mis;
`endif
    in_e.rd     = in_rd;
    in_e.is_fp  = in_rd_is_fp;
    in_e.we_int = in_reg_write & ~in_rd_is_fp & (in_rd != '0) & ~mis;
    in_e.we_fp  = in_reg_write & in_rd_is_fp & ~mis;
    in_e.data   = wb_select(in_wb_sel, in_alu_result,
                            load_extract(in_funct3, in_read_data), in_pc_plus4);
  end

  assign in_ready = ~s_vld_q;
  assign accept   = in_valid & in_ready;
  assign drain    = h_vld_q & wb_ready;

  // Skid occupancy: S only fills while H is stalled, and always refills H first
  always_comb begin
    h_d     = h_q;
    s_d     = s_q;
    h_vld_d = h_vld_q;
    s_vld_d = s_vld_q;
    cnt_d   = cnt_q + CNT_W'(drain);
    if (flush) begin
      h_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!h_vld_q) begin
      if (accept) begin
        h_d     = in_e;
        h_vld_d = 1'b1;
      end
    end else if (drain) begin
      if (s_vld_q) begin
        h_d     = s_q;
        s_vld_d = 1'b0;
      end else if (accept) begin
        h_d = in_e;
      end else begin
        h_vld_d = 1'b0;
      end
    end else if (accept) begin
      s_d     = in_e;
      s_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q     <= '0;
      s_q     <= '0;
      h_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      h_q     <= h_d;
      s_q     <= s_d;
      h_vld_q <= h_vld_d;
      s_vld_q <= s_vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_valid     = h_vld_q;
  assign wb_rd        = h_q.rd;
  assign wb_we_int    = h_vld_q & h_q.we_int;
  assign wb_we_fp     = h_vld_q & h_q.we_fp;
  assign wb_data      = h_q.data;
`ifdef MEM_WB_MISALIGN_TRAP_EN
  assign misalign_trap = h_vld_q & h_q.trap;
`endif
  assign fwd_valid    = h_vld_q & (h_q.we_int | h_q.we_fp);
  assign fwd_rd       = h_q.rd;
  assign fwd_is_fp    = h_q.is_fp;
  assign fwd_data     = h_q.data;
  assign retire_count = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (covers MEM_WB_MISALIGN_TRAP_EN when defined).
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write, in_rd_is_fp;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, in_pc_plus4, in_read_data;
  logic        flush;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic        wb_we_int, wb_we_fp;
  logic [31:0] wb_data;
  logic        misalign_trap;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic        fwd_is_fp;
  logic [31:0] fwd_data;
  logic [31:0] retire_count;

  int checks = 0;
  int failures = 0;

  mem_wb_stage dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_rd_is_fp(in_rd_is_fp),
    .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
    .in_read_data(in_read_data), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_we_int(wb_we_int), .wb_we_fp(wb_we_fp), .wb_data(wb_data),
`ifdef MEM_WB_MISALIGN_TRAP_EN
    .misalign_trap(misalign_trap),
`endif
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_is_fp(fwd_is_fp),
    .fwd_data(fwd_data), .retire_count(retire_count)
  );

`ifndef MEM_WB_MISALIGN_TRAP_EN
  assign misalign_trap = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic fp,
                       input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [31:0] rdata);
    in_valid = v; in_rd = rd; in_reg_write = rw; in_rd_is_fp = fp;
    in_wb_sel = sel; in_funct3 = f3; in_alu_result = alu; in_pc_plus4 = pc4;
    in_read_data = rdata;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
    #12;
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_wb_data", wb_data, 32'h0);
    chk("rst_retire", retire_count, 32'd0);
    chk("rst_fwd_valid", {31'b0, fwd_valid}, 32'd0);
    chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    wb_ready = 1'b1;
    drive(1'b1, 5'd5, 1'b1, 1'b0, 2'b01, 3'b000, 32'h100, 32'h0, 32'h000000F0);
    tick();
    chk("lb_valid", {31'b0, wb_valid}, 32'd1);
    chk("lb_data", wb_data, 32'hFFFFFFF0);
    chk("lb_we_int", {31'b0, wb_we_int}, 32'd1);
    chk("lb_rd", {27'b0, wb_rd}, 32'd5);
    chk("lb_fwd_valid", {31'b0, fwd_valid}, 32'd1);
    chk("lb_fwd_data", fwd_data, 32'hFFFFFFF0);
    chk("lb_retire", retire_count, 32'd0);

    drive(1'b1, 5'd5, 1'b1, 1'b0, 2'b01, 3'b100, 32'h100, 32'h0, 32'h000000F0);
    tick();
    chk("lbu_data", wb_data, 32'h000000F0);
    chk("lbu_retire", retire_count, 32'd1);

    drive(1'b1, 5'd6, 1'b1, 1'b0, 2'b01, 3'b001, 32'h100, 32'h0, 32'h12348001);
    tick();
    chk("lh_data", wb_data, 32'hFFFF8001);

    drive(1'b1, 5'd6, 1'b1, 1'b0, 2'b01, 3'b101, 32'h100, 32'h0, 32'h12348001);
    tick();
    chk("lhu_data", wb_data, 32'h00008001);

    drive(1'b1, 5'd0, 1'b1, 1'b1, 2'b01, 3'b010, 32'h100, 32'h0, 32'h3F800000);
    tick();
    chk("flw_data", wb_data, 32'h3F800000);
    chk("flw_we_fp", {31'b0, wb_we_fp}, 32'd1);
    chk("flw_we_int", {31'b0, wb_we_int}, 32'd0);
    chk("flw_fwd_is_fp", {31'b0, fwd_is_fp}, 32'd1);
    chk("flw_fwd_valid", {31'b0, fwd_valid}, 32'd1);

    drive(1'b1, 5'd0, 1'b1, 1'b0, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0);
    tick();
    chk("x0_valid", {31'b0, wb_valid}, 32'd1);
    chk("x0_we_int", {31'b0, wb_we_int}, 32'd0);
    chk("x0_fwd_valid", {31'b0, fwd_valid}, 32'd0);
    chk("x0_data", wb_data, 32'h55);

    drive(1'b1, 5'd1, 1'b1, 1'b0, 2'b10, 3'b000, 32'h55, 32'h00001004, 32'h0);
    tick();
    chk("link_data", wb_data, 32'h00001004);
    chk("link_retire", retire_count, 32'd6);

    drive(1'b1, 5'd3, 1'b1, 1'b0, 2'b11, 3'b000, 32'h77, 32'h88, 32'h99);
    tick();
    chk("sel11_data", wb_data, 32'h0);

    drive(1'b1, 5'd3, 1'b1, 1'b0, 2'b01, 3'b011, 32'h100, 32'h0, 32'hCAFEBABE);
    tick();
    chk("badf3_data", wb_data, 32'h0);

    in_valid = 1'b0;
    tick();
    chk("idle_valid", {31'b0, wb_valid}, 32'd0);
    chk("idle_retire", retire_count, 32'd9);

    wb_ready = 1'b0;
    drive(1'b1, 5'd1, 1'b1, 1'b0, 2'b00, 3'b000, 32'h11, 32'h0, 32'h0);
    tick();
    chk("bp_a_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_a_data", wb_data, 32'h11);
    drive(1'b1, 5'd2, 1'b1, 1'b0, 2'b00, 3'b000, 32'h22, 32'h0, 32'h0);
    tick();
    chk("bp_b_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_b_hold", wb_data, 32'h11);
    drive(1'b1, 5'd3, 1'b1, 1'b0, 2'b00, 3'b000, 32'h33, 32'h0, 32'h0);
    tick();
    chk("bp_c_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_c_hold", wb_data, 32'h11);
    chk("bp_c_rd", {27'b0, wb_rd}, 32'd1);
    chk("bp_c_retire", retire_count, 32'd9);
    in_valid = 1'b0; wb_ready = 1'b1;
    tick();
    chk("bp_d1_data", wb_data, 32'h22);
    chk("bp_d1_rd", {27'b0, wb_rd}, 32'd2);
    chk("bp_d1_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_d1_retire", retire_count, 32'd10);
    tick();
    chk("bp_d2_valid", {31'b0, wb_valid}, 32'd0);
    chk("bp_d2_retire", retire_count, 32'd11);

    wb_ready = 1'b0;
    drive(1'b1, 5'd4, 1'b1, 1'b0, 2'b00, 3'b000, 32'h44, 32'h0, 32'h0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 1'b0, 2'b00, 3'b000, 32'h45, 32'h0, 32'h0);
    tick();
    chk("fl_full_ready", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 5'd6, 1'b1, 1'b0, 2'b00, 3'b000, 32'h46, 32'h0, 32'h0);
    tick();
    chk("fl_valid", {31'b0, wb_valid}, 32'd0);
    chk("fl_ready", {31'b0, in_ready}, 32'd1);
    chk("fl_retire", retire_count, 32'd11);
    chk("fl_we_int", {31'b0, wb_we_int}, 32'd0);
    flush = 1'b0;
    drive(1'b1, 5'd7, 1'b1, 1'b0, 2'b00, 3'b000, 32'h47, 32'h0, 32'h0);
    tick();
    chk("fl2_valid", {31'b0, wb_valid}, 32'd1);
    in_valid = 1'b0; flush = 1'b1; wb_ready = 1'b1;
    tick();
    chk("fl2_drain_valid", {31'b0, wb_valid}, 32'd0);
    chk("fl2_drain_retire", retire_count, 32'd12);
    flush = 1'b0;

    drive(1'b1, 5'd7, 1'b1, 1'b0, 2'b01, 3'b010, 32'h102, 32'h0, 32'hDEADBEEF);
    tick();
    chk("lw_mis_valid", {31'b0, wb_valid}, 32'd1);
    chk("lw_mis_data", wb_data, 32'hDEADBEEF);
`ifdef MEM_WB_MISALIGN_TRAP_EN
    chk("lw_mis_trap", {31'b0, misalign_trap}, 32'd1);
    chk("lw_mis_we_int", {31'b0, wb_we_int}, 32'd0);
    chk("lw_mis_fwd", {31'b0, fwd_valid}, 32'd0);
`else
    chk("lw_mis_we_int", {31'b0, wb_we_int}, 32'd1);
`endif
    drive(1'b1, 5'd8, 1'b1, 1'b0, 2'b01, 3'b001, 32'h102, 32'h0, 32'hDEADBEEF);
    tick();
    chk("lh_al_data", wb_data, 32'hFFFFBEEF);
    chk("lh_al_we_int", {31'b0, wb_we_int}, 32'd1);
    chk("lh_al_retire", retire_count, 32'd13);
`ifdef MEM_WB_MISALIGN_TRAP_EN
    chk("lh_al_trap", {31'b0, misalign_trap}, 32'd0);
`endif
    drive(1'b1, 5'd9, 1'b1, 1'b0, 2'b01, 3'b101, 32'h101, 32'h0, 32'h0000ABCD);
    tick();
    chk("lhu_mis_data", wb_data, 32'h0000ABCD);
    chk("lhu_mis_retire", retire_count, 32'd14);
`ifdef MEM_WB_MISALIGN_TRAP_EN
    chk("lhu_mis_trap", {31'b0, misalign_trap}, 32'd1);
    chk("lhu_mis_we_int", {31'b0, wb_we_int}, 32'd0);
`endif
    in_valid = 1'b0;
    tick();
    chk("mis_retire", retire_count, 32'd15);

    wb_ready = 1'b0;
    drive(1'b1, 5'd10, 1'b1, 1'b0, 2'b00, 3'b000, 32'hA5A5A5A5, 32'h0, 32'h0);
    tick();
    chk("ar_pre_valid", {31'b0, wb_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, wb_valid}, 32'd0);
    chk("ar_data", wb_data, 32'h0);
    chk("ar_rd", {27'b0, wb_rd}, 32'd0);
    chk("ar_we_int", {31'b0, wb_we_int}, 32'd0);
    chk("ar_fwd_valid", {31'b0, fwd_valid}, 32'd0);
    chk("ar_retire", retire_count, 32'd0);
    chk("ar_ready", {31'b0, in_ready}, 32'd1);
    chk("ar_trap", {31'b0, misalign_trap}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
